// File: rtl/shift_unit_iterative.sv
// shift_unit_iterative
//   Multi-cycle barrel-shift replacement: a request is captured into a
//   working register and shifted by at most STEP positions per clock until
//   the requested distance has been covered, then held as the result.
//
// Ports
//   clk        : clock, rising edge
//   rst        : asynchronous active-high reset
//   in_valid   : request present
//   in_ready   : unit can take a request this cycle
//   in_data    : operand, N bits
//   in_amount  : shift distance 0..N-1, W bits
//   in_mode    : 0 LSL, 1 LSR, 2 ASR, 3 ROL, 4 ROR, 5-7 reserved (pass-through)
//   out_valid  : result present (DONE state)
//   out_ready  : consumer takes the result
//   out_data   : result (working register)
//   busy       : high while iterating (SHIFT state)
//
// Handshake: a transfer happens on a rising edge where valid & ready are both
// high. The producer holds valid and payload steady until the transfer; ready
// may depend combinationally on the opposite side's valid/ready. Here in_ready
// is high in IDLE, and in DONE when the result leaves on the same edge, which
// lets a new request follow a result with no idle cycle.
module shift_unit_iterative #(
  parameter int N    = 8,
  parameter int STEP = 1
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [N-1:0]         in_data,
  input  logic [$clog2(N)-1:0] in_amount,
  input  logic [2:0]           in_mode,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [N-1:0]         out_data,
  output logic                 busy
);

  localparam int W = $clog2(N);
  localparam logic [W-1:0] STEP_W = W'(STEP);

  localparam logic [2:0] MODE_LSL = 3'd0;
  localparam logic [2:0] MODE_LSR = 3'd1;
  localparam logic [2:0] MODE_ASR = 3'd2;
  localparam logic [2:0] MODE_ROL = 3'd3;
  localparam logic [2:0] MODE_ROR = 3'd4;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_t;

  state_t         state, state_n;
  logic [N-1:0]   work, work_n;
  logic [W-1:0]   remaining, remaining_n;
  logic [2:0]     mode, mode_n;

  logic           accept;
  logic [W-1:0]   s;
  logic [W:0]     rot_inv;
  logic [N-1:0]   shifted;

  assign in_ready  = (state == IDLE) | ((state == DONE) & out_ready);
  assign accept    = in_valid & in_ready;
  assign out_valid = (state == DONE);
  assign out_data  = work;
  assign busy      = (state == SHIFT);

  // Distance covered this cycle; only used in SHIFT where remaining > 0,
  // so s >= 1 and the rotate complement N - s stays inside 1..N-1.
  assign s       = (remaining < STEP_W) ? remaining : STEP_W;
  assign rot_inv = (W + 1)'(N) - {1'b0, s};

  // One iteration of the selected shift. ASR on the partially shifted value
  // still replicates the original MSB because earlier steps preserved it.
  always_comb begin
    shifted = work;
    case (mode)
      MODE_LSL: shifted = work << s;
      MODE_LSR: shifted = work >> s;
      MODE_ASR: shifted = N'($signed(work) >>> s);
      MODE_ROL: shifted = (work << s) | (work >> rot_inv);
      MODE_ROR: shifted = (work >> s) | (work << rot_inv);
      default:  shifted = work;
    endcase
  end

  always_comb begin
    state_n     = state;
    work_n      = work;
    remaining_n = remaining;
    mode_n      = mode;

    case (state)
      IDLE: ;
      SHIFT: begin
        work_n      = shifted;
        remaining_n = remaining - s;
        if (remaining == s) state_n = DONE;
      end
      DONE: if (out_ready) state_n = IDLE;
      default: state_n = IDLE;
    endcase

    // A new request overrides the DONE->IDLE step, giving back-to-back flow.
    // Zero distance and reserved modes skip SHIFT and present in_data as is.
    if (accept) begin
      work_n = in_data;
      mode_n = in_mode;
      if ((in_amount == '0) || (in_mode > MODE_ROR)) begin
        remaining_n = '0;
        state_n     = DONE;
      end else begin
        remaining_n = in_amount;
        state_n     = SHIFT;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      work      <= '0;
      remaining <= '0;
      mode      <= '0;
    end else begin
      state     <= state_n;
      work      <= work_n;
      remaining <= remaining_n;
      mode      <= mode_n;
    end
  end

endmodule

// File: tb/tb_shift_unit_iterative.sv
// tb_shift_unit_iterative
//   Two instances: u_a (N=8, STEP=1) and u_b (N=16, STEP=3). Directed steps
//   and random traffic are driven from one initial block; a forked monitor
//   compares every delivered result and its latency against queues filled
//   when each request is driven.
//   Latency here = rising edges after the accept edge up to the edge that
//   raises out_valid; pass-through requests are valid right after the
//   accept edge (latency 0 in this count, i.e. one cycle after the request).
module tb_shift_unit_iterative;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int errors = 0;
  int checks = 0;

  // instance A
  logic       a_in_valid, a_in_ready, a_out_valid, a_out_ready, a_busy;
  logic [7:0] a_in_data, a_out_data;
  logic [2:0] a_in_amount, a_in_mode;
  logic       a_or, a_rr, a_rand;
  assign a_out_ready = a_rand ? a_rr : a_or;

  // instance B
  logic        b_in_valid, b_in_ready, b_out_valid, b_out_ready, b_busy;
  logic [15:0] b_in_data, b_out_data;
  logic [3:0]  b_in_amount;
  logic [2:0]  b_in_mode;
  logic        b_or, b_rr, b_rand;
  assign b_out_ready = b_rand ? b_rr : b_or;

  logic [7:0]  a_exp_q[$];
  int          a_lat_q[$];
  logic [15:0] b_exp_q[$];
  int          b_lat_q[$];

  shift_unit_iterative #(.N(8), .STEP(1)) u_a (
    .clk(clk), .rst(rst),
    .in_valid(a_in_valid), .in_ready(a_in_ready), .in_data(a_in_data),
    .in_amount(a_in_amount), .in_mode(a_in_mode),
    .out_valid(a_out_valid), .out_ready(a_out_ready), .out_data(a_out_data),
    .busy(a_busy)
  );

  shift_unit_iterative #(.N(16), .STEP(3)) u_b (
    .clk(clk), .rst(rst),
    .in_valid(b_in_valid), .in_ready(b_in_ready), .in_data(b_in_data),
    .in_amount(b_in_amount), .in_mode(b_in_mode),
    .out_valid(b_out_valid), .out_ready(b_out_ready), .out_data(b_out_data),
    .busy(b_busy)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    checks++;
    assert (obs === expv) else begin
      errors++;
      $error("FAIL %s: observed %0h, expected %0h", tag, obs, expv);
    end
  endtask

  // Single-step reference shift for n in {8,16}, done in 32 bits.
  function automatic logic [15:0] ref_shift(input logic [15:0] d, input int k,
                                            input logic [2:0] m, input int n);
    logic [15:0] mask;
    logic [31:0] dd, sx, r;
    mask = (n == 16) ? 16'hFFFF : 16'h00FF;
    dd   = {16'h0000, d & mask};
    sx   = (n == 16) ? {{16{d[15]}}, d} : {{24{d[7]}}, d[7:0]};
    case (m)
      3'd0:    r = dd << k;
      3'd1:    r = dd >> k;
      3'd2:    r = sx >> k;
      3'd3:    r = (dd << k) | (dd >> (n - k));
      3'd4:    r = (dd >> k) | (dd << (n - k));
      default: r = dd;
    endcase
    return r[15:0] & mask;
  endfunction

  function automatic int exp_lat(input int k, input int m, input int step);
    return (k == 0 || m > 4) ? 0 : (k + step - 1) / step;
  endfunction

  // Call right after a rising edge (+1); returns right after the accept edge (+1).
  task automatic drive_a(input logic [7:0] d, input int k, input logic [2:0] m,
                         input logic [7:0] expv, input int lat, output int waits);
    a_in_data = d; a_in_amount = 3'(k); a_in_mode = m; a_in_valid = 1'b1;
    a_exp_q.push_back(expv);
    a_lat_q.push_back(lat);
    waits = 0;
    @(negedge clk);
    while (!a_in_ready && waits < 100) begin waits++; @(negedge clk); end
    check("a_accept", a_in_ready, 1);
    @(posedge clk); #1;
    a_in_valid = 1'b0;
  endtask

  task automatic drive_b(input logic [15:0] d, input int k, input logic [2:0] m,
                         input logic [15:0] expv, input int lat, output int waits);
    b_in_data = d; b_in_amount = 4'(k); b_in_mode = m; b_in_valid = 1'b1;
    b_exp_q.push_back(expv);
    b_lat_q.push_back(lat);
    waits = 0;
    @(negedge clk);
    while (!b_in_ready && waits < 100) begin waits++; @(negedge clk); end
    check("b_accept", b_in_ready, 1);
    @(posedge clk); #1;
    b_in_valid = 1'b0;
  endtask

  task automatic drain();
    int n = 0;
    @(negedge clk);
    while ((a_exp_q.size() != 0 || b_exp_q.size() != 0) && n < 300) begin
      n++;
      @(negedge clk);
    end
    check("drain_pending", 32'(a_exp_q.size() + b_exp_q.size()), 0);
  endtask

  task automatic ready_gen();
    forever begin
      @(posedge clk); #1;
      a_rr = 1'($urandom_range(0, 1));
      b_rr = 1'($urandom_range(0, 1));
    end
  endtask

  // Samples on the falling edge; handshakes seen here happen on the next rise.
  task automatic monitor();
    int a_acc = 0, b_acc = 0;
    bit a_first = 0, b_first = 0, a_hold = 0, b_hold = 0;
    logic [7:0]  a_hd = '0;
    logic [15:0] b_hd = '0;
    forever begin
      @(negedge clk);
      if (rst) begin
        a_first = 0; b_first = 0; a_hold = 0; b_hold = 0;
      end else begin
        check("a_busy", a_busy, !a_out_valid && !a_in_ready);
        if (a_hold) begin
          check("a_hold_valid", a_out_valid, 1);
          check("a_hold_data", a_out_data, a_hd);
        end
        if (a_out_valid && a_first) begin
          a_first = 0;
          if (a_lat_q.size() > 0) check("a_latency", cyc - a_acc - 1, a_lat_q.pop_front());
        end
        if (a_out_valid && a_out_ready) begin
          if (a_exp_q.size() == 0) check("a_spurious_result", a_out_valid, 0);
          else check("a_data", a_out_data, a_exp_q.pop_front());
        end
        a_hold = a_out_valid && !a_out_ready;
        a_hd   = a_out_data;
        if (a_in_valid && a_in_ready) begin a_acc = cyc; a_first = 1; end

        check("b_busy", b_busy, !b_out_valid && !b_in_ready);
        if (b_hold) begin
          check("b_hold_valid", b_out_valid, 1);
          check("b_hold_data", b_out_data, b_hd);
        end
        if (b_out_valid && b_first) begin
          b_first = 0;
          if (b_lat_q.size() > 0) check("b_latency", cyc - b_acc - 1, b_lat_q.pop_front());
        end
        if (b_out_valid && b_out_ready) begin
          if (b_exp_q.size() == 0) check("b_spurious_result", b_out_valid, 0);
          else check("b_data", b_out_data, b_exp_q.pop_front());
        end
        b_hold = b_out_valid && !b_out_ready;
        b_hd   = b_out_data;
        if (b_in_valid && b_in_ready) begin b_acc = cyc; b_first = 1; end
      end
    end
  endtask

  initial begin
    int w, n, k, m;
    logic [15:0] d16, r16;

    rst = 1'b1;
    a_in_valid = 1'b1; a_in_data = 8'hFF; a_in_amount = 3'd1; a_in_mode = 3'd0;
    b_in_valid = 1'b1; b_in_data = 16'hFFFF; b_in_amount = 4'd1; b_in_mode = 3'd0;
    a_or = 1'b1; a_rr = 1'b1; a_rand = 1'b0;
    b_or = 1'b1; b_rr = 1'b1; b_rand = 1'b0;
    fork
      monitor();
      ready_gen();
    join_none

    // reset values with in_valid held high
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_a_out_valid", a_out_valid, 0);
    check("rst_a_out_data", a_out_data, 0);
    check("rst_a_busy", a_busy, 0);
    check("rst_a_in_ready", a_in_ready, 1);
    check("rst_b_out_valid", b_out_valid, 0);
    check("rst_b_out_data", b_out_data, 0);
    check("rst_b_busy", b_busy, 0);
    check("rst_b_in_ready", b_in_ready, 1);
    a_in_valid = 1'b0;
    b_in_valid = 1'b0;
    @(posedge clk); #1;
    rst = 1'b0;

    // directed, STEP=1
    drive_a(8'b1001_0110, 3, 3'd0, 8'b1011_0000, 3, w);
    check("a_first_edge_accept_waits", w, 0);
    drive_a(8'b1001_0110, 3, 3'd1, 8'b0001_0010, 3, w);
    drive_a(8'b1001_0110, 2, 3'd2, 8'b1110_0101, 2, w);
    drive_a(8'b1001_0110, 3, 3'd3, 8'b1011_0100, 3, w);
    drive_a(8'b1001_0110, 3, 3'd4, 8'b1101_0010, 3, w);
    drive_a(8'hA5, 0, 3'd0, 8'hA5, 0, w);
    drive_a(8'hA5, 5, 3'd6, 8'hA5, 0, w);
    drive_a(8'h3C, 2, 3'd7, 8'h3C, 0, w);
    drive_a(8'h01, 7, 3'd4, 8'h02, 7, w);
    drive_a(8'h81, 7, 3'd2, 8'hFF, 7, w);
    drain();

    // backpressure, then back-to-back accept as the result leaves
    @(posedge clk); #1;
    a_or = 1'b0;
    drive_a(8'h01, 1, 3'd0, 8'h02, 1, w);
    n = 0;
    @(negedge clk);
    while (!a_out_valid && n < 50) begin n++; @(negedge clk); end
    repeat (5) begin
      check("bp_out_valid", a_out_valid, 1);
      check("bp_out_data", a_out_data, 8'h02);
      check("bp_in_ready", a_in_ready, 0);
      @(negedge clk);
    end
    @(posedge clk); #1;
    a_or = 1'b1;
    drive_a(8'h80, 7, 3'd1, 8'h01, 7, w);
    check("bp_b2b_waits", w, 0);
    drain();

    // reset in the second SHIFT cycle of a 5-cycle operation
    @(posedge clk); #1;
    drive_a(8'hFF, 5, 3'd0, 8'hE0, 5, w);
    @(posedge clk); #1;
    rst = 1'b1;
    a_exp_q.delete();
    a_lat_q.delete();
    @(negedge clk);
    check("abort_out_valid", a_out_valid, 0);
    check("abort_out_data", a_out_data, 0);
    check("abort_busy", a_busy, 0);
    check("abort_in_ready", a_in_ready, 1);
    @(posedge clk); #1;
    rst = 1'b0;
    repeat (8) begin
      @(negedge clk);
      check("abort_no_result", a_out_valid, 0);
    end
    @(posedge clk); #1;
    drive_a(8'h0F, 4, 3'd4, 8'hF0, 4, w);
    drain();

    // directed, N=16 STEP=3
    @(posedge clk); #1;
    drive_b(16'h0001, 7, 3'd0, 16'h0080, 3, w);
    drive_b(16'h0001, 15, 3'd0, 16'h8000, 5, w);
    drive_b(16'h8001, 4, 3'd2, 16'hF800, 2, w);
    drive_b(16'h1234, 4, 3'd4, 16'h4123, 2, w);
    drive_b(16'h1234, 8, 3'd3, 16'h3412, 3, w);
    drive_b(16'hBEEF, 0, 3'd3, 16'hBEEF, 0, w);
    drain();

    // random traffic with random consumer stalls
    @(posedge clk); #1;
    a_rand = 1'b1;
    repeat (500) begin
      d16 = 16'($urandom);
      k = $urandom_range(0, 7);
      m = $urandom_range(0, 7);
      r16 = ref_shift({8'h00, d16[7:0]}, k, 3'(m), 8);
      drive_a(d16[7:0], k, 3'(m), r16[7:0], exp_lat(k, m, 1), w);
      n = $urandom_range(0, 2);
      repeat (n) begin @(posedge clk); #1; end
    end
    drain();
    a_rand = 1'b0;

    @(posedge clk); #1;
    b_rand = 1'b1;
    repeat (500) begin
      d16 = 16'($urandom);
      k = $urandom_range(0, 15);
      m = $urandom_range(0, 7);
      r16 = ref_shift(d16, k, 3'(m), 16);
      drive_b(d16, k, 3'(m), r16, exp_lat(k, m, 3), w);
      n = $urandom_range(0, 2);
      repeat (n) begin @(posedge clk); #1; end
    end
    drain();
    b_rand = 1'b0;

    repeat (2) @(posedge clk);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/shift_unit_iterative.md
SHIFT_UNIT_ITERATIVE -- requirements
Module: shift_unit_iterative

Interface
REQ-001 SHALL have parameter N, default 8: data width in bits, N >= 2, N a power of two.
REQ-002 SHALL have parameter STEP, default 1: maximum bit positions shifted per cycle, 1 <= STEP <= N-1.
REQ-003 SHALL derive localparam W = $clog2(N): shift-amount width.
REQ-004 SHALL have port clk, input, 1: single clock; all state changes on rising edge.
REQ-005 SHALL have port rst, input, 1: reset, asynchronous, active-high.
REQ-006 SHALL have port in_valid, input, 1: request present.
REQ-007 SHALL have port in_ready, output, 1: unit can accept a request this cycle.
REQ-008 SHALL have port in_data, input, N: operand.
REQ-009 SHALL have port in_amount, input, W: shift distance 0..N-1.
REQ-010 SHALL have port in_mode, input, 3: 0 LSL, 1 LSR, 2 ASR, 3 ROL, 4 ROR, 5-7 reserved.
REQ-011 SHALL have port out_valid, output, 1: result present.
REQ-012 SHALL have port out_ready, input, 1: consumer takes the result.
REQ-013 SHALL have port out_data, output, N: result.
REQ-014 SHALL have port busy, output, 1: high in SHIFT state.

Function
REQ-015 SHALL implement FSM states IDLE, SHIFT, DONE.
REQ-016 SHALL accept a request on a rising edge with in_valid & in_ready; in_data, in_amount, in_mode are captured at that edge only.
REQ-017 SHALL drive in_ready = (state == IDLE) | (state == DONE & out_ready), combinationally.
REQ-018 On accept with in_amount == 0 or a reserved mode: SHALL load in_data unchanged and go to DONE; latency 1 cycle.
REQ-019 On accept with in_amount = k > 0 and a valid mode: SHALL load in_data, set remaining = k, go to SHIFT.
REQ-020 In SHIFT, each edge SHALL shift the working register by s = min(STEP, remaining) and subtract s from remaining.
REQ-021 SHALL go from SHIFT to DONE on the edge where remaining reaches 0; latency = ceil(k/STEP) cycles from the accept edge to out_valid.
REQ-022 Shift semantics: LSL fills with 0 at the LSB. LSR fills with 0 at the MSB. ASR replicates the original MSB. ROL/ROR rotate with no bit loss.
REQ-023 The final result SHALL equal the single-step reference (a << k, a >> k, $signed(a) >>> k, rotate by k) truncated to N bits.
REQ-024 out_valid SHALL be 1 exactly in DONE.
REQ-025 out_data SHALL equal the working register and SHALL hold stable while out_valid & !out_ready.
REQ-026 In DONE with out_ready & !in_valid: SHALL return to IDLE; out_valid drops next cycle.
REQ-027 In DONE with out_ready & in_valid: SHALL complete the result and accept the new request on the same edge (back-to-back, no bubble); next state per REQ-018/019.
REQ-028 In SHIFT: in_ready = 0; in_valid SHALL be ignored and out_ready has no effect.
REQ-029 busy SHALL be 1 exactly in SHIFT.

Reset
REQ-030 While rst = 1: SHALL force state IDLE, working register 0, remaining 0; outputs out_valid = 0, out_data = 0, busy = 0, in_ready = 1; in_valid ignored.
REQ-031 rst asserted mid-SHIFT or in DONE SHALL abort the operation immediately with no result emitted.
REQ-032 SHALL accept a request on the first rising edge after rst deasserts.

Verification (N=8 unless noted)
REQ-033 STEP=1, LSL 8'b1001_0110 by 3 -> out_valid 3 cycles after accept, out_data 8'b1011_0000; LSR by 3 -> 8'b0001_0010.
REQ-034 STEP=1, ASR 8'b1001_0110 by 2 -> 8'b1110_0101 after 2 cycles; ROL by 3 -> 8'b1011_0100; ROR by 3 -> 8'b1101_0010.
REQ-035 Amount 0 or mode 6 with 8'hA5 -> out_data 8'hA5, 1-cycle latency; STEP=3, LSL 8'h01 by 7 -> 8'h80 after 3 cycles.
REQ-036 Backpressure: out_ready = 0 for 5 cycles in DONE -> out_valid and out_data stable, in_ready 0; then out_ready = 1 with in_valid = 1 -> new request accepted on the same edge.
REQ-037 rst pulsed in SHIFT cycle 2 of a 5-cycle op -> out_valid never asserts; all outputs 0; next request after reset gives a correct result.
REQ-038 Random: 1000 requests, all modes, N in {8,16}, STEP in {1,3}, random in_valid/out_ready -> every result matches REQ-023 and each latency matches REQ-021.
